// File: rtl/uart_tx_arbiter_if.sv
// Frame-source and UART-controller signal bundle for uart_tx_arbiter.
// master: arbiter side; slave: requesters plus controller side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned FRAME_BYTES = 18
);
    localparam int unsigned GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned FRAME_W = FRAME_BYTES * 8;

    logic [NUM_REQ-1:0]         req_vld;
    logic [NUM_REQ*FRAME_W-1:0] req_data;
    logic [NUM_REQ-1:0]         req_ack;
    logic [FRAME_W-1:0]         ctrl_tx_data;
    logic                       ctrl_tx_vld;
    logic                       ctrl_tx_rdy;
    logic [GRANT_W-1:0]         grant_id;
    logic                       busy;
    logic [15:0]                frame_cnt;
    logic                       err_timeout;

    modport master (
        input  req_vld, req_data, ctrl_tx_rdy,
        output req_ack, ctrl_tx_data, ctrl_tx_vld, grant_id, busy, frame_cnt, err_timeout
    );

    modport slave (
        output req_vld, req_data, ctrl_tx_rdy,
        input  req_ack, ctrl_tx_data, ctrl_tx_vld, grant_id, busy, frame_cnt, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART frame transmitter among NUM_REQ sources,
// with accept-retry and a completion watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned FRAME_BYTES    = 18,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int unsigned GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned FRAME_W = FRAME_BYTES * 8;
    localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StWaitAcc,
        StWaitDone
    } state_t;

    state_t             r_state, w_state_next;
    logic [NUM_REQ-1:0] r_ack, w_ack_next;
    logic [FRAME_W-1:0] r_data, w_data_next;
    logic               r_vld, w_vld_next;
    logic [GRANT_W-1:0] r_grant, w_grant_next;
    logic               r_busy, w_busy_next;
    logic [15:0]        r_cnt, w_cnt_next;
    logic               r_err, w_err_next;
    logic [1:0]         r_acc, w_acc_next;
    logic [WD_W-1:0]    r_wd, w_wd_next;

    logic               w_found;
    logic [GRANT_W-1:0] w_winner;
    logic [FRAME_W-1:0] w_slice;

    // Search upward from the slot after the last grant, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_grant;
        w_slice  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && bus.req_vld[(32'(r_grant) + k) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = GRANT_W'((32'(r_grant) + k) % NUM_REQ);
                w_slice  = bus.req_data[((32'(r_grant) + k) % NUM_REQ) * FRAME_W +: FRAME_W];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ack_next   = '0;
        w_vld_next   = 1'b0;
        w_data_next  = r_data;
        w_grant_next = r_grant;
        w_busy_next  = r_busy;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;
        w_acc_next   = r_acc;
        w_wd_next    = r_wd;
        case (r_state)
            StIdle: begin
                if (bus.ctrl_tx_rdy && w_found) begin
                    w_data_next  = w_slice;
                    w_vld_next   = 1'b1;
                    w_ack_next   = NUM_REQ'(1) << w_winner;
                    w_grant_next = w_winner;
                    w_busy_next  = 1'b1;
                    w_acc_next   = '0;
                    w_state_next = StWaitAcc;
                end
            end
            StWaitAcc: begin
                if (!bus.ctrl_tx_rdy) begin
                    w_wd_next    = '0;
                    w_state_next = StWaitDone;
                end else if (r_acc == 2'd3) begin
                    // Controller missed the offer: present the frame again.
                    w_vld_next = 1'b1;
                    w_acc_next = '0;
                end else begin
                    w_acc_next = r_acc + 2'd1;
                end
            end
            StWaitDone: begin
                if (bus.ctrl_tx_rdy) begin
                    w_cnt_next   = r_cnt + 16'd1;
                    w_busy_next  = 1'b0;
                    w_state_next = StIdle;
                end else if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    w_err_next   = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = StIdle;
                end else begin
                    w_wd_next = r_wd + WD_W'(1);
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_ack   <= '0;
            r_data  <= '0;
            r_vld   <= 1'b0;
            r_grant <= GRANT_W'(NUM_REQ - 1);
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_acc   <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
            r_data  <= w_data_next;
            r_vld   <= w_vld_next;
            r_grant <= w_grant_next;
            r_busy  <= w_busy_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
            r_acc   <= w_acc_next;
            r_wd    <= w_wd_next;
        end
    end

    assign bus.req_ack      = r_ack;
    assign bus.ctrl_tx_data = r_data;
    assign bus.ctrl_tx_vld  = r_vld;
    assign bus.grant_id     = r_grant;
    assign bus.busy         = r_busy;
    assign bus.frame_cnt    = r_cnt;
    assign bus.err_timeout  = r_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: controller model, cycle-level reference model and
// directed scenarios with literal expectations.
module tb_uart_tx_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned FB = 18;
    localparam int unsigned FW = FB * 8;
    localparam int unsigned TO = 600;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .FRAME_BYTES(FB)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .FRAME_BYTES   (FB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Controller: ignores c_ignore offers, drops rdy after an accepted offer,
    // raises it again c_delay cycles later unless c_hang is set.
    int c_ignore = 0;
    int c_delay  = 10;
    int c_low    = 0;
    bit c_hang   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ctrl_tx_rdy <= 1'b1;
            c_low           <= 0;
        end else if (bus.ctrl_tx_rdy) begin
            if (bus.ctrl_tx_vld) begin
                if (c_ignore > 0) begin
                    c_ignore <= c_ignore - 1;
                end else begin
                    bus.ctrl_tx_rdy <= 1'b0;
                    c_low           <= 0;
                end
            end
        end else begin
            c_low <= c_low + 1;
            if (!c_hang && (c_low + 1 >= c_delay)) bus.ctrl_tx_rdy <= 1'b1;
        end
    end

    // Reference model, stepped once per edge from the values sampled at that edge.
    localparam int PhIdle = 0, PhOffer = 1, PhSend = 2;
    int            m_phase = PhIdle;
    int            m_grant = NR - 1;
    bit            m_busy  = 1'b0;
    logic [15:0]   m_cnt   = '0;
    bit            m_err   = 1'b0;
    logic [FW-1:0] m_data  = '0;
    int            m_acc   = 0;
    int            m_wd    = 0;

    int cyc = 0;
    int ack_hits [NR];
    int grant_log[$];
    int vld_times[$];
    int busy_cycles = 0;

    always @(posedge clk) begin : model
        logic [NR-1:0]    s_vld;
        logic             s_rdy;
        logic [NR*FW-1:0] s_data;
        logic [NR-1:0]    e_ack;
        logic             e_vld;
        bit               found;
        int               w;
        s_vld  = bus.req_vld;
        s_rdy  = bus.ctrl_tx_rdy;
        s_data = bus.req_data;
        e_ack  = '0;
        e_vld  = 1'b0;
        if (rst) begin
            m_phase = PhIdle;
            m_grant = NR - 1;
            m_busy  = 1'b0;
            m_cnt   = '0;
            m_err   = 1'b0;
            m_data  = '0;
            m_acc   = 0;
            m_wd    = 0;
        end else begin
            case (m_phase)
                PhIdle: begin
                    if (s_rdy && s_vld != '0) begin
                        found = 1'b0;
                        w     = 0;
                        for (int k = 1; k <= NR; k++) begin
                            if (!found && s_vld[(m_grant + k) % NR]) begin
                                found = 1'b1;
                                w     = (m_grant + k) % NR;
                            end
                        end
                        m_grant  = w;
                        m_data   = s_data[w*FW +: FW];
                        e_ack[w] = 1'b1;
                        e_vld    = 1'b1;
                        m_busy   = 1'b1;
                        m_acc    = 0;
                        m_phase  = PhOffer;
                    end
                end
                PhOffer: begin
                    if (!s_rdy) begin
                        m_wd    = 0;
                        m_phase = PhSend;
                    end else begin
                        m_acc++;
                        if (m_acc == 4) begin
                            e_vld = 1'b1;
                            m_acc = 0;
                        end
                    end
                end
                PhSend: begin
                    if (s_rdy) begin
                        m_cnt   = m_cnt + 16'd1;
                        m_busy  = 1'b0;
                        m_phase = PhIdle;
                    end else begin
                        m_wd++;
                        if (m_wd == TO) begin
                            m_err   = 1'b1;
                            m_busy  = 1'b0;
                            m_phase = PhIdle;
                        end
                    end
                end
                default: m_phase = PhIdle;
            endcase
        end
        #1;
        chk("req_ack", FW'(bus.req_ack), FW'(e_ack));
        chk("ctrl_tx_vld", FW'(bus.ctrl_tx_vld), FW'(e_vld));
        chk("ctrl_tx_data", bus.ctrl_tx_data, m_data);
        chk("grant_id", FW'(bus.grant_id), FW'(m_grant));
        chk("busy", FW'(bus.busy), FW'(m_busy));
        chk("frame_cnt", FW'(bus.frame_cnt), FW'(m_cnt));
        chk("err_timeout", FW'(bus.err_timeout), FW'(m_err));
        cyc++;
        for (int i = 0; i < NR; i++) if (bus.req_ack[i]) ack_hits[i]++;
        if (bus.req_ack != '0) grant_log.push_back(int'(bus.grant_id));
        if (bus.ctrl_tx_vld) vld_times.push_back(cyc);
        if (bus.busy) busy_cycles++;
    end

    task automatic clear_stats();
        for (int i = 0; i < NR; i++) ack_hits[i] = 0;
        grant_log.delete();
        vld_times.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic wait_ack(input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (bus.req_ack == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ack_seen"}, FW'(bus.req_ack != '0), FW'(1));
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_reached"}, FW'(bus.busy), FW'(0));
    endtask

    function automatic int log_at(input int i);
        return (i < grant_log.size()) ? grant_log[i] : 99;
    endfunction

    task automatic check_reset_values(input string name);
        chk({name, "_ack"}, FW'(bus.req_ack), FW'(0));
        chk({name, "_vld"}, FW'(bus.ctrl_tx_vld), FW'(0));
        chk({name, "_data"}, bus.ctrl_tx_data, FW'(0));
        chk({name, "_grant"}, FW'(bus.grant_id), FW'(3));
        chk({name, "_busy"}, FW'(bus.busy), FW'(0));
        chk({name, "_cnt"}, FW'(bus.frame_cnt), FW'(0));
        chk({name, "_err"}, FW'(bus.err_timeout), FW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int b0;
        bus.req_vld = '0;
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < FB; j++)
                bus.req_data[i*FW + FW - 1 - 8*j -: 8] = 8'(i * 32 + j);
        clear_stats();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Single requester, 500-cycle frame on the wire.
        c_delay = 500;
        b0 = busy_cycles;
        bus.req_vld = 4'b0001;
        @(negedge clk);
        chk("t1_ack", FW'(bus.req_ack), FW'(4'b0001));
        chk("t1_vld", FW'(bus.ctrl_tx_vld), FW'(1));
        chk("t1_grant", FW'(bus.grant_id), FW'(0));
        chk("t1_data", bus.ctrl_tx_data, 144'h000102030405060708090A0B0C0D0E0F1011);
        bus.req_vld = '0;
        wait_idle(1000, "t1");
        chk("t1_busy_len", FW'(busy_cycles - b0), FW'(502));
        chk("t1_cnt", FW'(bus.frame_cnt), FW'(1));

        // All four requesting for eight frames.
        do_reset();
        c_delay = 10;
        bus.req_vld = 4'b1111;
        for (int n = 0; n < 8; n++) wait_ack(100, "t2");
        bus.req_vld = '0;
        wait_idle(100, "t2");
        chk("t2_cnt", FW'(bus.frame_cnt), FW'(8));
        chk("t2_log_len", FW'(grant_log.size()), FW'(8));
        for (int i = 0; i < 8; i++) chk("t2_order", FW'(log_at(i)), FW'(i % 4));
        for (int i = 0; i < NR; i++) chk("t2_ack_hits", FW'(ack_hits[i]), FW'(2));

        // Pointer wrap: 1, then 3, then 2 and 3 pending -> 2 before 3.
        do_reset();
        bus.req_vld = 4'b0010;
        wait_ack(20, "t3a");
        bus.req_vld = '0;
        wait_idle(100, "t3a");
        bus.req_vld = 4'b1000;
        wait_ack(20, "t3b");
        bus.req_vld = 4'b1100;
        wait_idle(100, "t3b");
        wait_ack(20, "t3c");
        bus.req_vld = 4'b1000;
        wait_idle(100, "t3c");
        wait_ack(20, "t3d");
        bus.req_vld = '0;
        wait_idle(100, "t3d");
        chk("t3_g0", FW'(log_at(0)), FW'(1));
        chk("t3_g1", FW'(log_at(1)), FW'(3));
        chk("t3_g2", FW'(log_at(2)), FW'(2));
        chk("t3_g3", FW'(log_at(3)), FW'(3));
        chk("t3_no_req0", FW'(ack_hits[0]), FW'(0));

        // Controller misses the first offer.
        do_reset();
        c_ignore = 1;
        bus.req_vld = 4'b0001;
        wait_ack(20, "t4");
        bus.req_vld = '0;
        wait_idle(100, "t4");
        chk("t4_pulses", FW'(vld_times.size()), FW'(2));
        if (vld_times.size() >= 2)
            chk("t4_gap", FW'(vld_times[1] - vld_times[0]), FW'(4));
        chk("t4_cnt", FW'(bus.frame_cnt), FW'(1));

        // Watchdog: controller never finishes.
        do_reset();
        c_hang = 1'b1;
        b0 = busy_cycles;
        bus.req_vld = 4'b0001;
        wait_ack(20, "t5");
        wait_idle(2 * TO, "t5");
        chk("t5_err", FW'(bus.err_timeout), FW'(1));
        chk("t5_busy", FW'(bus.busy), FW'(0));
        chk("t5_cnt", FW'(bus.frame_cnt), FW'(0));
        chk("t5_busy_len", FW'(busy_cycles - b0), FW'(TO + 2));
        repeat (20) @(negedge clk);
        chk("t5_no_regrant", FW'(ack_hits[0]), FW'(1));
        c_hang = 1'b0;
        wait_ack(10, "t5r");
        chk("t5r_ack", FW'(bus.req_ack), FW'(4'b0001));
        bus.req_vld = '0;
        wait_idle(100, "t5r");
        chk("t5r_cnt", FW'(bus.frame_cnt), FW'(1));
        chk("t5r_err_sticky", FW'(bus.err_timeout), FW'(1));

        // Asynchronous reset in the middle of a frame.
        do_reset();
        c_delay = 100;
        bus.req_vld = 4'b1111;
        wait_ack(20, "t6a");
        wait_idle(200, "t6a");
        wait_ack(20, "t6b");
        repeat (5) @(negedge clk);
        chk("t6_pre_busy", FW'(bus.busy), FW'(1));
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("t6_async");
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        wait_ack(20, "t6c");
        chk("t6_first_ack", FW'(bus.req_ack), FW'(4'b0001));
        chk("t6_first_grant", FW'(bus.grant_id), FW'(0));
        bus.req_vld = '0;
        wait_idle(200, "t6c");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
